// File: rtl/fpu_pkg.sv
// Shared FP32 types and constants for the multiplier back end.
package fpu_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_IN_W = 10;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    logic                       sign;
    logic signed [EXP_IN_W-1:0] exp;
    logic [MAN_W-1:0]           frac;
    logic                       g;
    logic                       sticky;
    logic                       is_nan;
    logic                       is_inf;
    logic                       is_zero;
  } s1_payload_t;

endpackage

// File: rtl/fpu_rne_round.sv
// Round-to-nearest-even on a normalized fraction; a rounding carry bumps the exponent.
module fpu_rne_round #(
  parameter int SIZE_MAN    = 23,
  parameter int SIZE_EXP_IN = 10
) (
  input  logic [SIZE_MAN-1:0]           frac,
  input  logic                          g,
  input  logic                          sticky,
  input  logic signed [SIZE_EXP_IN-1:0] exp,
  output logic [SIZE_MAN-1:0]           frac_r,
  output logic signed [SIZE_EXP_IN-1:0] exp_r,
  output logic                          inexact
);

  logic round_up;
  logic carry;

  assign round_up = g & (sticky | frac[0]);
  // Carry out only happens for an all-ones fraction, so frac_r wraps to zero.
  assign {carry, frac_r} = {1'b0, frac} + {{SIZE_MAN{1'b0}}, round_up};
  assign exp_r   = exp + {{(SIZE_EXP_IN-1){1'b0}}, carry};
  assign inexact = g | sticky;

endmodule

// File: rtl/fpu_mul_round_pack.sv
// FP32 multiplier back end: normalize (S1), round and pack (S2), valid/ready pipeline.
module fpu_mul_round_pack
  import fpu_pkg::*;
#(
  parameter int SIZE_EXP    = EXP_W,
  parameter int SIZE_MAN    = MAN_W,
  parameter int SIZE_EXP_IN = EXP_IN_W
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_sign,
  input  logic signed [SIZE_EXP_IN-1:0] i_exp,
  input  logic [2*(SIZE_MAN+1)-1:0]     i_mant,
  input  logic                          i_is_nan,
  input  logic                          i_is_inf,
  input  logic                          i_is_zero,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [31:0]                   o_result,
  output logic                          o_overflow,
  output logic                          o_underflow,
  output logic                          o_inexact
);

  localparam int P = 2 * (SIZE_MAN + 1);
  localparam logic signed [SIZE_EXP_IN-1:0] EXP_ONE  = SIZE_EXP_IN'(1);
  localparam logic signed [SIZE_EXP_IN-1:0] EXP_SAT  = SIZE_EXP_IN'(EXP_MAX);
  localparam logic signed [SIZE_EXP_IN-1:0] EXP_ZERO = SIZE_EXP_IN'(0);

  s1_payload_t s1_d, s1_q;
  logic        s1_valid, s2_valid;
  logic        s1_advance, accept;

  logic [SIZE_MAN-1:0]           frac_r;
  logic signed [SIZE_EXP_IN-1:0] exp_r;
  logic                          rnd_inexact;

  fp32_t pack_res;
  logic  pack_ovf, pack_unf, pack_inx;

  // S1 may move whenever S2 is empty or draining; o_ready never looks at i_valid.
  assign s1_advance = !s2_valid | i_ready;
  assign o_ready    = !s1_valid | s1_advance;
  assign accept     = i_valid & o_ready;
  assign o_valid    = s2_valid;

  always_comb begin
    s1_d         = '0;
    s1_d.sign    = i_sign;
    s1_d.is_nan  = i_is_nan;
    s1_d.is_inf  = i_is_inf;
    s1_d.is_zero = i_is_zero;
    if (i_mant[P-1]) begin
      s1_d.frac   = i_mant[P-2 -: SIZE_MAN];
      s1_d.g      = i_mant[P-2-SIZE_MAN];
      s1_d.sticky = |i_mant[P-3-SIZE_MAN:0];
      s1_d.exp    = i_exp + EXP_ONE;
    end else begin
      s1_d.frac   = i_mant[P-3 -: SIZE_MAN];
      s1_d.g      = i_mant[P-3-SIZE_MAN];
      s1_d.sticky = |i_mant[P-4-SIZE_MAN:0];
      s1_d.exp    = i_exp;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (o_ready) s1_valid <= i_valid;
      if (accept)  s1_q     <= s1_d;
    end
  end

  fpu_rne_round #(
    .SIZE_MAN    (SIZE_MAN),
    .SIZE_EXP_IN (SIZE_EXP_IN)
  ) u_round (
    .frac    (s1_q.frac),
    .g       (s1_q.g),
    .sticky  (s1_q.sticky),
    .exp     (s1_q.exp),
    .frac_r  (frac_r),
    .exp_r   (exp_r),
    .inexact (rnd_inexact)
  );

  always_comb begin
    pack_res      = '0;
    pack_res.sign = s1_q.sign;
    pack_ovf      = 1'b0;
    pack_unf      = 1'b0;
    pack_inx      = 1'b0;
    if (s1_q.is_nan) begin
      pack_res = QNAN;
    end else if (s1_q.is_inf) begin
      pack_res.exp = '1;
    end else if (s1_q.is_zero) begin
      pack_res.exp = '0;
    end else if (exp_r >= EXP_SAT) begin
      pack_res.exp = '1;
      pack_ovf     = 1'b1;
      pack_inx     = 1'b1;
    end else if (exp_r <= EXP_ZERO) begin
      // Denormal results are flushed rather than produced.
      pack_unf = 1'b1;
      pack_inx = 1'b1;
    end else begin
      pack_res.exp  = exp_r[SIZE_EXP-1:0];
      pack_res.frac = frac_r;
      pack_inx      = rnd_inexact;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid    <= 1'b0;
      o_result    <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      o_inexact   <= 1'b0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        o_result    <= pack_res;
        o_overflow  <= pack_ovf;
        o_underflow <= pack_unf;
        o_inexact   <= pack_inx;
      end
    end
  end

endmodule
